reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  Integer register file; responder side of the rf_read_req/rf_read_rsp protocol issued by the read stage.
//  Serves two independent read ports (rs1, rs2) with configurable read latency and a done/valid handshake.
//  Accepts one write per cycle from writeback. Sits beside the read stage; x0 hardwired to zero.
// PARAMETERS
//  NREGS     32  number of architectural registers (address width = $clog2(NREGS))
//  XLEN      32  register width in bits
//  READ_LAT  1   cycles from request acceptance to done; 0 = combinational done in request cycle
// PORTS
//  clk              in   1       clock, all state on posedge
//  rst              in   1       synchronous reset, active-high
//  rs1_rf_read_req  in   struct  core::rf_read_req_t {addr[$clog2(NREGS)-1:0], en}
//  rs2_rf_read_req  in   struct  core::rf_read_req_t, same as rs1
//  rf_write_req     in   struct  core::rf_write_req_t {addr, value[XLEN-1:0], en}
//  rs1_rf_read_rsp  out  struct  core::rf_read_rsp_t {value[XLEN-1:0], done, valid}
//  rs2_rf_read_rsp  out  struct  core::rf_read_rsp_t, same as rs1
//  inj_par_err      in   1       (RF_PARITY_EN only) corrupt parity of the write in this cycle
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: all registers = 0, both port FSMs IDLE, rsp.value=0, done=0, valid=0.
//  - Write: on posedge with rf_write_req.en && addr!=0, regs[addr] <= value. Writes to x0 are dropped.
//  - Read value = regs[addr], forwarded: if rf_write_req.en && write addr==read addr && addr!=0, return write value
//    (same-cycle bypass). addr==0 always returns 0.
//  - Per-port FSM (READ_LAT>=1), counter cnt width $clog2(READ_LAT+1):
//    IDLE: done=0. en -> BUSY, latch addr, cnt=READ_LAT-1 (READ_LAT==1 -> DONE directly).
//    BUSY: done=0. cnt decrements each cycle; cnt==0 -> DONE. en drop -> IDLE.
//      addr != latched addr -> restart BUSY with new addr.
//    DONE: done=1, value tracks regs/bypass every cycle while held (stalled initiator sees fresh data).
//      en drop -> IDLE. addr change -> BUSY (restart), done=0 that cycle.
//  - READ_LAT==0: no FSM; done = en, value combinational, same cycle.
//  - Latency: request first seen in cycle N -> done=1 in cycle N+READ_LAT.
//  - Back-to-back: addr change while DONE costs READ_LAT cycles (no pipelining across addresses).
//  - Ports are fully independent; rs1 and rs2 on same address both served, no arbitration.
//  - valid = done && !parity_error; when done=0, valid=0 and value is don't-care but held stable.
//  - Reset asserted mid-read: FSM to IDLE next cycle, done=0; request must be re-issued after reset.
//  - Request with en=0 never changes state beyond IDLE; addr ignored.
// CONFIGURATION
//  RF_PARITY_EN defined: one even-parity bit stored per register, computed on write
//    (inverted when inj_par_err=1). Parity checked on every read in DONE (or READ_LAT==0 done);
//    mismatch -> done=1, valid=0. Bypassed write data always valid=1. x0 never errors.
//    inj_par_err port present.
//  RF_PARITY_EN undefined: no parity storage, no inj_par_err port, valid == done.
// TESTING
//  1 Reset then rs1 read addr 5, READ_LAT=1 -> done=1,valid=1,value=0 one cycle after en.
//  2 Write x7=0xDEADBEEF; same cycle rs2 read x7, READ_LAT=0 -> value=0xDEADBEEF,done=1 same cycle (bypass).
//  3 Write x0=0x1234, then read x0 on both ports -> value=0,valid=1.
//  4 READ_LAT=3, read x3, change addr to x4 in BUSY -> done rises 3 cycles after change, value=regs[4].
//  5 Hold en in DONE 4 cycles, write x3=0x55 in cycle 2 -> value switches to 0x55 in that cycle, done stays 1.
//  6 RF_PARITY_EN: write x9=0xA with inj_par_err=1, read x9 -> done=1,valid=0; rewrite clean -> valid=1.
//  Also: assert rst in BUSY -> done=0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/reg_file_if.sv
// reg_file_if: read-request/response and write-request bundle between the
// read stage / writeback (master) and the register file (slave).
//   rs1_req_*, rs2_req_* : read requests {addr, en}          master -> slave
//   wr_req_*             : write request {addr, value, en}   master -> slave
//   rs1_rsp_*, rs2_rsp_* : read responses {value, done, valid} slave -> master
interface reg_file_if #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_req_addr;
  logic            rs1_req_en;
  logic [AW-1:0]   rs2_req_addr;
  logic            rs2_req_en;

  logic [AW-1:0]   wr_req_addr;
  logic [XLEN-1:0] wr_req_value;
  logic            wr_req_en;

  logic [XLEN-1:0] rs1_rsp_value;
  logic            rs1_rsp_done;
  logic            rs1_rsp_valid;
  logic [XLEN-1:0] rs2_rsp_value;
  logic            rs2_rsp_done;
  logic            rs2_rsp_valid;

  modport master (
    output rs1_req_addr, rs1_req_en, rs2_req_addr, rs2_req_en,
    output wr_req_addr, wr_req_value, wr_req_en,
    input  rs1_rsp_value, rs1_rsp_done, rs1_rsp_valid,
    input  rs2_rsp_value, rs2_rsp_done, rs2_rsp_valid
  );

  modport slave (
    input  rs1_req_addr, rs1_req_en, rs2_req_addr, rs2_req_en,
    input  wr_req_addr, wr_req_value, wr_req_en,
    output rs1_rsp_value, rs1_rsp_done, rs1_rsp_valid,
    output rs2_rsp_value, rs2_rsp_done, rs2_rsp_valid
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: integer register file with two independent read ports (rs1, rs2)
// and one write port. x0 reads as zero and ignores writes. Each read port
// answers with done after READ_LAT cycles of a stable request (READ_LAT=0:
// combinational done). Same-cycle write data is bypassed to readers.
// Ports:
//   clk          clock, all state on posedge
//   rst          synchronous reset, active-high
//   inj_par_err  (RF_PARITY_EN only) store inverted parity for this cycle's write
//   rf           reg_file_if.slave: read requests/responses and write request
// Optional feature: define RF_PARITY_EN for per-register even parity; a
// parity mismatch on a read gives done=1, valid=0.
module reg_file #(
  parameter int NREGS    = 32,
  parameter int XLEN     = 32,
  parameter int READ_LAT = 1
) (
  input logic       clk,
  input logic       rst,
`ifdef RF_PARITY_EN
  input logic       inj_par_err,
`endif
  reg_file_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [XLEN-1:0] regs      [NREGS];
  logic [AW-1:0]   req_addr  [2];
  logic            req_en    [2];
  logic [XLEN-1:0] fresh     [2];
  logic [XLEN-1:0] rsp_value [2];
  logic [XLEN-1:0] held      [2];
  logic            bypass    [2];
  logic            par_err   [2];
  logic            done      [2];
  logic            wr_hit;

  always_comb begin
    req_addr[0] = rf.rs1_req_addr;
    req_en[0]   = rf.rs1_req_en;
    req_addr[1] = rf.rs2_req_addr;
    req_en[1]   = rf.rs2_req_en;
  end

  assign wr_hit = rf.wr_req_en && (rf.wr_req_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[rf.wr_req_addr] <= rf.wr_req_value;
    end
  end

  // Read data: x0 is zero, a same-cycle write to the address wins over storage.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      bypass[p] = wr_hit && (rf.wr_req_addr == req_addr[p]);
      if (req_addr[p] == '0)  fresh[p] = '0;
      else if (bypass[p])     fresh[p] = rf.wr_req_value;
      else                    fresh[p] = regs[req_addr[p]];
    end
  end

`ifdef RF_PARITY_EN
  logic par [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) par[i] <= 1'b0;
    end else if (wr_hit) begin
      par[rf.wr_req_addr] <= (^rf.wr_req_value) ^ inj_par_err;
    end
  end

  // Bypassed data never went through storage, so it cannot carry an error.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      par_err[p] = (req_addr[p] != '0) && !bypass[p] &&
                   (par[req_addr[p]] != (^regs[req_addr[p]]));
    end
  end
`else
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) par_err[p] = 1'b0;
  end
`endif

  if (READ_LAT == 0) begin : g_comb
    always_comb begin
      for (int unsigned p = 0; p < 2; p++) done[p] = req_en[p];
    end
  end else begin : g_fsm
    localparam int CW = $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LAT - 1);

    logic [1:0]    state [2];
    logic [CW-1:0] cnt   [2];
    logic [AW-1:0] laddr [2];

    // The BUSY->DONE move itself takes a cycle, so BUSY leaves on cnt==1;
    // this keeps done at exactly READ_LAT cycles after the request appears.
    always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (rst || !req_en[p]) begin
          state[p] <= S_IDLE;
          if (rst) begin
            cnt[p]   <= '0;
            laddr[p] <= '0;
          end
        end else if (state[p] == S_IDLE || req_addr[p] != laddr[p]) begin
          laddr[p] <= req_addr[p];
          cnt[p]   <= CNT_INIT;
          state[p] <= (READ_LAT == 1) ? S_DONE : S_BUSY;
        end else if (state[p] == S_BUSY) begin
          if (cnt[p] == CW'(1)) state[p] <= S_DONE;
          cnt[p] <= cnt[p] - CW'(1);
        end
      end
    end

    // An address change or dropped enable kills done in the same cycle.
    always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
        done[p] = (state[p] == S_DONE) && req_en[p] && (req_addr[p] == laddr[p]);
      end
    end
  end

  // While not done the response value holds its last driven value.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) rsp_value[p] = done[p] ? fresh[p] : held[p];
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (rst) held[p] <= '0;
      else     held[p] <= rsp_value[p];
    end
  end

  assign rf.rs1_rsp_value = rsp_value[0];
  assign rf.rs1_rsp_done  = done[0];
  assign rf.rs1_rsp_valid = done[0] && !par_err[0];
  assign rf.rs2_rsp_value = rsp_value[1];
  assign rf.rs2_rsp_done  = done[1];
  assign rf.rs2_rsp_valid = done[1] && !par_err[1];
endmodule
